// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and counter sizing.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/addsub_n.sv
// N-bit adder/subtractor: b is XOR-conditioned by as, which also feeds the carry-in.
module addsub_n #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         as,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0] sum;

    assign sum  = {1'b0, a} + {1'b0, b ^ {N{as}}} + {{N{1'b0}}, as};
    assign s    = sum[N-1:0];
    assign cout = sum[N];

endmodule

// File: rtl/restoring_div.sv
// Multi-cycle restoring divider with start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (adds the FIX sign-correction state).
module restoring_div
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo_acc, rem_acc, dsr;
    logic [WIDTH-1:0] dividend_mag, divisor_mag;
    logic [WIDTH-1:0] quo_next, rem_next;
    logic [WIDTH:0]   rem_shift, trial, zero_ext;
    logic             trial_cout;
    logic             last_iter;

    assign zero_ext  = '0;
    assign rem_shift = {rem_acc, quo_acc[WIDTH-1]};
    // cout=1 means no borrow: the trial difference replaces the partial remainder
    assign quo_next  = {quo_acc[WIDTH-2:0], trial_cout};
    assign rem_next  = trial_cout ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign last_iter = (cnt == CW'(1));

`ifdef DIV_SIGNED_EN
    logic             neg_q, neg_r;
    logic [WIDTH:0]   as_a, as_b, rem_neg;
    logic             rem_neg_cout;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic             unused_bits;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    assign dividend_mag = magnitude(dividend);
    assign divisor_mag  = magnitude(divisor);

    // The trial subtractor doubles as the quotient negator during FIX
    always_comb begin
        as_a = rem_shift;
        as_b = {1'b0, dsr};
        if (state == S_FIX) begin
            as_a = zero_ext;
            as_b = {1'b0, quo_acc};
        end
    end

    addsub_n #(.N(WIDTH + 1)) u_trial (
        .a    (as_a),
        .b    (as_b),
        .as   (1'b1),
        .s    (trial),
        .cout (trial_cout)
    );

    addsub_n #(.N(WIDTH + 1)) u_rem_neg (
        .a    (zero_ext),
        .b    ({1'b0, rem_acc}),
        .as   (1'b1),
        .s    (rem_neg),
        .cout (rem_neg_cout)
    );

    assign q_fix       = neg_q ? trial[WIDTH-1:0] : quo_acc;
    assign r_fix       = neg_r ? rem_neg[WIDTH-1:0] : rem_acc;
    assign unused_bits = ^{rem_neg[WIDTH], rem_neg_cout};
`else
    logic unused_bits;

    assign dividend_mag = dividend;
    assign divisor_mag  = divisor;

    addsub_n #(.N(WIDTH + 1)) u_trial (
        .a    (rem_shift),
        .b    ({1'b0, dsr}),
        .as   (1'b1),
        .s    (trial),
        .cout (trial_cout)
    );

    assign unused_bits = trial[WIDTH];
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = (divisor == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                if (last_iter) begin
`ifdef DIV_SIGNED_EN
                    state_next = S_FIX;
`else
                    state_next = S_DONE;
`endif
                end
            end
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state == S_RUN) || (state == S_FIX);
    assign done = (state == S_DONE);

    // Working registers carry no reset; they are always loaded on an accepted start
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            quo_acc <= dividend_mag;
            rem_acc <= '0;
            dsr     <= divisor_mag;
`ifdef DIV_SIGNED_EN
            neg_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r   <= dividend[WIDTH-1];
`endif
        end else if (state == S_RUN) begin
            quo_acc <= quo_next;
            rem_acc <= rem_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt         <= CW'(WIDTH);
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    cnt <= cnt - CW'(1);
`ifndef DIV_SIGNED_EN
                    if (last_iter) begin
                        quotient  <= quo_next;
                        remainder <= rem_next;
                    end
`endif
                end
`ifdef DIV_SIGNED_EN
                S_FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_div.sv
// Self-checking bench for restoring_div: directed cases plus random operands vs. an arithmetic model.
module tb_restoring_div;
    import div_pkg::*;

    localparam int W = DEF_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int total = 0;
    int bad = 0;

    restoring_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [W-1:0] dd, input logic [W-1:0] dv,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic f, output int lat, output int bsy);
        if (dv == '0) begin
            q   = '1;
            r   = dd;
            f   = 1'b1;
            lat = 1;
            bsy = 0;
        end else begin
`ifdef DIV_SIGNED_EN
            int sdd, sdv;
            sdd = int'($signed(dd));
            sdv = int'($signed(dv));
            q   = W'(sdd / sdv);
            r   = W'(sdd % sdv);
            lat = W + 2;
            bsy = W + 1;
`else
            q   = dd / dv;
            r   = dd % dv;
            lat = W + 1;
            bsy = W;
`endif
            f = 1'b0;
        end
    endtask

    task automatic run_div(input logic [W-1:0] dd, input logic [W-1:0] dv,
                           input bit poke_run, input bit poke_done);
        logic [W-1:0] eq, er;
        logic         ef;
        int           elat, ebsy, lat, bsy;
        bit           seen;
        model(dd, dv, eq, er, ef, elat, ebsy);
        @(negedge clk);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat  = 1;
        bsy  = 0;
        seen = 1'b0;
        while (!seen && lat <= 20) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) bsy++;
                if (poke_run && lat == 2) begin
                    start    = 1'b1;
                    dividend = W'($urandom);
                    divisor  = W'($urandom_range(1, (1 << W) - 1));
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                lat++;
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'(elat));
        chk("busy_cycles", 32'(bsy), 32'(ebsy));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("quotient", 32'(quotient), 32'(eq));
        chk("remainder", 32'(remainder), 32'(er));
        chk("div_by_zero", 32'(div_by_zero), 32'(ef));
        if (poke_done) begin
            start    = 1'b1;
            dividend = ~dd;
            divisor  = W'(1);
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("q_held", 32'(quotient), 32'(eq));
        chk("r_held", 32'(remainder), 32'(er));
        chk("flag_held", 32'(div_by_zero), 32'(ef));
        if (poke_done) begin
            @(negedge clk);
            chk("start_in_done_ignored", 32'(busy | done), 32'd0);
            chk("q_still_held", 32'(quotient), 32'(eq));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_flag", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_div(W'(13), W'(4), 1'b0, 1'b0);
        run_div(W'(15), W'(1), 1'b0, 1'b1);
        run_div(W'(0),  W'(7), 1'b0, 1'b0);
        run_div(W'(5),  W'(9), 1'b0, 1'b0);
        run_div(W'(9),  W'(0), 1'b0, 1'b1);
        run_div(W'(8),  W'(2), 1'b0, 1'b0);
        run_div(W'(13), W'(4), 1'b1, 1'b0);
        run_div(W'(9),  W'(2), 1'b0, 1'b0);
        run_div(W'(8),  W'(15), 1'b0, 1'b0);
        run_div(W'(15), W'(1), 1'b0, 1'b0);

        // Abort mid-operation with asynchronous reset
        @(negedge clk);
        start    = 1'b1;
        dividend = W'(13);
        divisor  = W'(4);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_q", 32'(quotient), 32'd0);
        chk("abort_r", 32'(remainder), 32'd0);
        chk("abort_flag", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        run_div(W'(6), W'(3), 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] dd, dv;
            dd = W'($urandom);
            dv = ($urandom_range(0, 6) == 0) ? '0 : W'($urandom);
            run_div(dd, dv, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
